// File: rtl/machv_pkg.sv
// Shared constants for the machv core: data width, register addressing
// and the load-type encodings carried in Funct3.
package machv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extender.sv
// Picks the byte/halfword lane of a loaded word and extends it to XLEN.
// Purely combinational so the store/AMO path can share it.
module load_extender
  import machv_pkg::*;
(
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [1:0]      offset,
  input  logic [2:0]      Funct3W,
  output logic [XLEN-1:0] ExtDataW
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  assign byte_w = ReadDataW[{offset, 3'b000} +: 8];
  assign half_w = offset[1] ? ReadDataW[31:16]
                            : ReadDataW[15:0];

  always_comb begin
    ExtDataW = ReadDataW;
    case (Funct3W)
      F3_LB:   ExtDataW = {{24{byte_w[7]}}, byte_w};
      F3_LH:   ExtDataW = {{16{half_w[15]}}, half_w};
      F3_LBU:  ExtDataW = {24'h0, byte_w};
      F3_LHU:  ExtDataW = {16'h0, half_w};
      default: ExtDataW = ReadDataW;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, load extension and the integer
// register file with write-through Decode read ports.
module writeback_regfile
  import machv_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegW,
  input  logic [XLEN-1:0]       ReadDataW,
  input  logic [XLEN-1:0]       ComputeResultW,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic [2:0]            Funct3W,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  output logic [XLEN-1:0]       RD1D,
  output logic [XLEN-1:0]       RD2D,
  output logic [XLEN-1:0]       ResultW,
  output logic                  WriteFireW
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            fire_q;
  logic            fire_d;
  logic            we;
  logic [XLEN-1:0] load_w;

  load_extender u_ext (
    .ReadDataW (ReadDataW),
    .offset    (ComputeResultW[1:0]),
    .Funct3W   (Funct3W),
    .ExtDataW  (load_w)
  );

  assign ResultW = MemtoRegW ? load_w : ComputeResultW;
  assign we      = RegWriteW && (rdW != '0);
  assign fire_d  = we;

  // Reset has priority: a write on the reset edge is dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      fire_q <= 1'b0;
    end else begin
      if (we) begin
        regs_q[rdW] <= ResultW;
      end
      fire_q <= fire_d;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(
    input logic [REG_ADDR_W-1:0] rs
  );
    if (rs == '0) begin
      return '0;
    end else if (BYPASS_EN && RegWriteW && (rdW == rs)) begin
      return ResultW;
    end else begin
      return regs_q[rs];
    end
  endfunction

  assign RD1D       = rd_port(rs1D);
  assign RD2D       = rd_port(rs2D);
  assign WriteFireW = fire_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: bypass and non-bypass builds
// share stimulus; expectations are queued on drive, checked at negedge.
module tb_writeback_regfile;
  import machv_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] ReadDataW;
  logic [31:0] ComputeResultW;
  logic [4:0]  rdW;
  logic [2:0]  Funct3W;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic [31:0] RD1D, RD2D, ResultW;
  logic        WriteFireW;
  logic [31:0] nb_RD1D, nb_RD2D, nb_ResultW;
  logic        nb_WriteFireW;

  always #5 CLK = ~CLK;

  writeback_regfile #(.NUM_REGS(32), .BYPASS_EN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ComputeResultW(ComputeResultW), .rdW(rdW),
    .Funct3W(Funct3W), .rs1D(rs1D), .rs2D(rs2D),
    .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
    .WriteFireW(WriteFireW)
  );

  writeback_regfile #(.NUM_REGS(32), .BYPASS_EN(1'b0)) dut_nb (
    .CLK(CLK), .RESET(RESET), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ComputeResultW(ComputeResultW), .rdW(rdW),
    .Funct3W(Funct3W), .rs1D(rs1D), .rs2D(rs2D),
    .RD1D(nb_RD1D), .RD2D(nb_RD2D), .ResultW(nb_ResultW),
    .WriteFireW(nb_WriteFireW)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] m[32];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel,
                      input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t        e;
    logic [31:0] got;
    @(negedge CLK);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       got = RD1D;
        1:       got = RD2D;
        2:       got = ResultW;
        3:       got = {31'h0, WriteFireW};
        4:       got = nb_RD1D;
        5:       got = nb_RD2D;
        default: got = nb_ResultW;
      endcase
      chk(e.tag, got, e.exp);
    end
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_t;

  ld_t ld_tab[11];

  initial begin
    ld_tab[0]  = '{F3_LB,  2'd0, 32'h00000002};
    ld_tab[1]  = '{F3_LB,  2'd3, 32'hFFFFFF80};
    ld_tab[2]  = '{F3_LBU, 2'd3, 32'h00000080};
    ld_tab[3]  = '{F3_LH,  2'd2, 32'hFFFF80F1};
    ld_tab[4]  = '{F3_LHU, 2'd2, 32'h000080F1};
    ld_tab[5]  = '{F3_LW,  2'd0, 32'h80F17F02};
    ld_tab[6]  = '{F3_LH,  2'd1, 32'h00007F02};
    ld_tab[7]  = '{F3_LB,  2'd1, 32'h0000007F};
    ld_tab[8]  = '{F3_LB,  2'd2, 32'hFFFFFFF1};
    ld_tab[9]  = '{F3_LBU, 2'd2, 32'h000000F1};
    ld_tab[10] = '{3'b011, 2'd1, 32'h80F17F02};

    RESET = 1'b1; RegWriteW = 1'b0; MemtoRegW = 1'b0;
    ReadDataW = '0; ComputeResultW = '0; rdW = '0;
    Funct3W = F3_LW; rs1D = 5'd5; rs2D = 5'd31;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    push("rst_rd1", 0, 32'h0);
    push("rst_rd2", 1, 32'h0);
    push("rst_fire", 3, 32'h0);
    cycle();

    RegWriteW = 1'b1; ComputeResultW = 32'hDEADBEEF;
    rdW = 5'd7; rs1D = 5'd7;
    push("alu_bypass", 0, 32'hDEADBEEF);
    push("alu_result", 2, 32'hDEADBEEF);
    push("alu_nb_old", 4, 32'h0);
    cycle();
    RegWriteW = 1'b0;
    push("alu_stored", 0, 32'hDEADBEEF);
    push("alu_fire", 3, 32'h1);
    push("alu_nb_new", 4, 32'hDEADBEEF);
    cycle();

    MemtoRegW = 1'b1; ReadDataW = 32'h80F17F02;
    push("ld_fire_lo", 3, 32'h0);
    foreach (ld_tab[i]) begin
      Funct3W = ld_tab[i].f3;
      ComputeResultW = {28'h1000, 2'b00, ld_tab[i].off};
      push($sformatf("ld_%0d", i), 2, ld_tab[i].exp);
      cycle();
    end

    RegWriteW = 1'b1; rdW = 5'd12; rs2D = 5'd12;
    Funct3W = F3_LB; ComputeResultW = 32'h00000103;
    push("ld_wr_bypass", 1, 32'hFFFFFF80);
    cycle();
    RegWriteW = 1'b0; ReadDataW = 32'h0;
    push("ld_wr_stored", 1, 32'hFFFFFF80);
    cycle();

    MemtoRegW = 1'b0; RegWriteW = 1'b1; rdW = 5'd0;
    ComputeResultW = 32'h12345678; rs1D = 5'd0; rs2D = 5'd0;
    push("x0_rd1", 0, 32'h0);
    push("x0_rd2", 1, 32'h0);
    push("x0_result", 2, 32'h12345678);
    cycle();
    RegWriteW = 1'b0;
    push("x0_rd1_next", 0, 32'h0);
    push("x0_fire", 3, 32'h0);
    cycle();

    RegWriteW = 1'b1; rdW = 5'd3; ComputeResultW = 32'h55;
    cycle();
    RESET = 1'b1; ComputeResultW = 32'hAA; rs1D = 5'd3;
    push("rstw_bypass", 0, 32'hAA);
    cycle();
    RESET = 1'b0; RegWriteW = 1'b0; rs2D = 5'd7;
    push("rstw_x3", 0, 32'h0);
    push("rstw_x7", 1, 32'h0);
    push("rstw_fire", 3, 32'h0);
    cycle();

    RegWriteW = 1'b1; rdW = 5'd9; rs1D = 5'd9;
    ComputeResultW = 32'h0BADF00D;
    push("x9_bypass", 0, 32'h0BADF00D);
    push("x9_nb_old", 4, 32'h0);
    cycle();
    RegWriteW = 1'b0; rs2D = 5'd9;
    push("x9_nb_new", 4, 32'h0BADF00D);
    push("x9_nb_rd2", 5, 32'h0BADF00D);
    push("x9_rd2", 1, 32'h0BADF00D);
    cycle();

    foreach (m[i]) m[i] = 32'h0;
    m[9] = 32'h0BADF00D;
    begin
      logic        prev;
      logic        w;
      logic [31:0] v;
      prev = 1'b0;
      for (int n = 0; n < 60; n++) begin
        w = 1'($urandom_range(0, 1));
        v = $urandom;
        RegWriteW = w; rdW = 5'($urandom);
        rs1D = 5'($urandom); rs2D = (n % 4 == 0) ? rdW : 5'($urandom);
        ComputeResultW = v;
        push("rnd_rd1", 0, (rs1D == 0) ? 32'h0 :
             (w && rdW == rs1D) ? v : m[rs1D]);
        push("rnd_rd2", 1, (rs2D == 0) ? 32'h0 :
             (w && rdW == rs2D) ? v : m[rs2D]);
        push("rnd_nb_rd1", 4, (rs1D == 0) ? 32'h0 : m[rs1D]);
        push("rnd_fire", 3, {31'h0, prev});
        if (w && rdW != 0) m[rdW] = v;
        prev = w && (rdW != 0);
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
